// File: rtl/mips_mem_arb_pkg.sv
// mips_mem_arb_pkg: shared types and counter widths for the unified-memory arbiter.
package mips_mem_arb_pkg;
    typedef enum logic {IDLE, ACCESS} state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;
    localparam int LAT_W = 4;
    localparam int STARVE_W = 4;
endpackage

// File: rtl/mips_mem_arb_pick.sv
// mips_mem_arb_pick: combinational winner select; data wins unless fetch is starved.
module mips_mem_arb_pick
    import mips_mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic dm_req,
    input  logic halted,
    input  logic starved,
    output logic valid,
    output logic owner
);
    logic if_ok;
    assign if_ok = if_req && !halted;
    assign valid = if_ok || dm_req;
    assign owner = (if_ok && (starved || !dm_req)) ? OWN_IF : OWN_DM;
endmodule

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: single-port memory arbiter between IF fetch and MEM load/store.
// Optional performance counters are enabled with `define MEM_ARB_PERF_EN.
module mips_mem_arbiter
    import mips_mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int MEM_LAT = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          halted,
    output logic          busy,
    output logic          stall_if
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]   perf_if_cnt,
    output logic [31:0]   perf_dm_cnt,
    output logic [31:0]   perf_conflict_cnt
`endif
);
    state_t state, state_nx;
    owner_t owner;
    logic [LAT_W-1:0] lat;
    logic [STARVE_W-1:0] starve;
    logic resp, arb, first, win, pick_valid, pick_own, pick_dm;

    assign resp = state == ACCESS && lat == LAT_W'(MEM_LAT);
    assign first = state == ACCESS && lat == '0;
    assign arb = state == IDLE || resp;
    assign win = arb && pick_valid;
    assign pick_dm = pick_own == OWN_DM;

    mips_mem_arb_pick u_pick (
        .if_req  (if_req),
        .dm_req  (dm_req),
        .halted  (halted),
        .starved (starve == STARVE_W'(STARVE_MAX)),
        .valid   (pick_valid),
        .owner   (pick_own)
    );

    always_comb begin
        state_nx = state;
        if (win)
            state_nx = ACCESS;
        else if (resp)
            state_nx = IDLE;
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            lat       <= '0;
            starve    <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state <= state_nx;
            lat   <= win ? '0 : (state == ACCESS ? lat + 1'b1 : lat);
            if (win) begin
                owner     <= owner_t'(pick_own);
                mem_we    <= pick_dm && dm_we;
                mem_addr  <= pick_dm ? dm_addr : if_addr;
                mem_wdata <= pick_dm ? dm_wdata : '0;
            end
            // halted freezes the starvation count; otherwise a lost eligible fetch counts up
            if (arb && !halted)
                starve <= (!if_req || !pick_dm) ? '0 :
                          (starve != STARVE_W'(STARVE_MAX) ? starve + 1'b1 : starve);
        end
    end

    assign mem_en    = first;
    assign busy      = state == ACCESS;
    assign if_gnt    = first && owner == OWN_IF;
    assign dm_gnt    = first && owner == OWN_DM;
    // rvalid is gated by reset so an access cut off by reset never responds
    assign if_rvalid = rst_n && resp && owner == OWN_IF;
    assign dm_rvalid = rst_n && resp && owner == OWN_DM;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = (dm_rvalid && !mem_we) ? mem_rdata : '0;
    assign stall_if  = rst_n && if_req && !halted && !if_gnt;

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            perf_if_cnt       <= '0;
            perf_dm_cnt       <= '0;
            perf_conflict_cnt <= '0;
        end else begin
            if (win && !pick_dm && perf_if_cnt != '1)
                perf_if_cnt <= perf_if_cnt + 1'b1;
            if (win && pick_dm && perf_dm_cnt != '1)
                perf_dm_cnt <= perf_dm_cnt + 1'b1;
            if (arb && if_req && !halted && dm_req && perf_conflict_cnt != '1)
                perf_conflict_cnt <= perf_conflict_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter: directed checks of the arbiter at MEM_LAT=1 and MEM_LAT=3.
module tb_mips_mem_arbiter;
    logic        clk1 = 1'b0;
    logic        rst_n, halted;
    logic        if_req, if_gnt, if_rvalid, dm_req, dm_we, dm_gnt, dm_rvalid;
    logic        mem_en, mem_we, busy, stall_if;
    logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        b_if_req, b_if_gnt, b_if_rvalid, b_dm_req, b_dm_we, b_dm_gnt, b_dm_rvalid;
    logic        b_mem_en, b_mem_we, b_busy, b_stall_if;
    logic [31:0] b_if_addr, b_if_rdata, b_dm_addr, b_dm_wdata, b_dm_rdata;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] p_if, p_dm, p_cf, b_p_if, b_p_dm, b_p_cf;
`endif
    logic [31:0] mem [0:255];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk1 = ~clk1;

    assign mem_rdata   = mem[mem_addr[7:0]];
    assign b_mem_rdata = mem[b_mem_addr[7:0]];

    always @(posedge clk1) begin
        if (mem_en && mem_we)
            mem[mem_addr[7:0]] <= mem_wdata;
        if (b_mem_en && b_mem_we)
            mem[b_mem_addr[7:0]] <= b_mem_wdata;
    end

    mips_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) u1 (
        .clk1(clk1), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .halted(halted), .busy(busy), .stall_if(stall_if)
`ifdef MEM_ARB_PERF_EN
        , .perf_if_cnt(p_if), .perf_dm_cnt(p_dm), .perf_conflict_cnt(p_cf)
`endif
    );

    mips_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .STARVE_MAX(4)) u3 (
        .clk1(clk1), .rst_n(rst_n),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid),
        .if_rdata(b_if_rdata),
        .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
        .dm_gnt(b_dm_gnt), .dm_rvalid(b_dm_rvalid), .dm_rdata(b_dm_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .halted(halted), .busy(b_busy), .stall_if(b_stall_if)
`ifdef MEM_ARB_PERF_EN
        , .perf_if_cnt(b_p_if), .perf_dm_cnt(b_p_dm), .perf_conflict_cnt(b_p_cf)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0]  seq;
        logic [13:0] gm, vm;
        int got, stall_lo, gcnt, scnt, blo, bad;
        for (int i = 0; i < 256; i++)
            mem[i] = 32'h0;
        mem[5]   = 32'h14431000;
        mem[200] = 32'd7;
        rst_n = 1'b0; halted = 1'b0;
        if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        b_if_req = 1'b0; b_if_addr = '0; b_dm_req = 1'b0; b_dm_we = 1'b0; b_dm_addr = '0; b_dm_wdata = '0;
        repeat (3) tick();
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_mem_en", {31'b0, mem_en}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_gnt", {30'b0, if_gnt, dm_gnt}, 0);
        check("rst_rvalid", {30'b0, if_rvalid, dm_rvalid}, 0);
        check("rst_stall", {31'b0, stall_if}, 0);
        rst_n = 1'b1;
        tick();

        // fetch alone
        if_req = 1'b1; if_addr = 32'd5;
        #1 check("fetch_stall", {31'b0, stall_if}, 1);
        tick();
        check("fetch_gnt", {31'b0, if_gnt}, 1);
        check("fetch_mem_en", {31'b0, mem_en}, 1);
        check("fetch_addr", mem_addr, 5);
        check("fetch_we", {31'b0, mem_we}, 0);
        check("fetch_busy", {31'b0, busy}, 1);
        if_req = 1'b0;
        tick();
        check("fetch_rvalid", {31'b0, if_rvalid}, 1);
        check("fetch_rdata", if_rdata, 32'h14431000);
        check("fetch_en_off", {31'b0, mem_en}, 0);
        tick();
        check("fetch_idle", {30'b0, busy, if_rvalid}, 0);

        // store alone
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'd198; dm_wdata = 32'd5040;
        tick();
        check("st_gnt", {31'b0, dm_gnt}, 1);
        check("st_en_we", {30'b0, mem_en, mem_we}, 3);
        check("st_addr", mem_addr, 198);
        check("st_wdata", mem_wdata, 5040);
        dm_req = 1'b0;
        tick();
        check("st_ack", {31'b0, dm_rvalid}, 1);
        check("st_rdata", dm_rdata, 0);
        check("st_en_off", {31'b0, mem_en}, 0);
        check("st_written", mem[198], 5040);
        tick();

        // both held: starvation rotation
        if_req = 1'b1; if_addr = 32'd5; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'd200;
        #1 check("both_stall", {31'b0, stall_if}, 1);
        seq = '0; got = 0; stall_lo = 0;
        for (int c = 0; c < 120 && got < 10; c++) begin
            tick();
            if (dm_gnt || if_gnt) begin
                seq = {seq[8:0], if_gnt};
                got++;
            end
            if (!if_gnt && !stall_if)
                stall_lo++;
        end
        check("starve_count", got, 10);
        check("starve_order", {22'b0, seq}, 32'b0000100001);
        check("starve_stall_lo", stall_lo, 0);
        if_req = 1'b0; dm_req = 1'b0;
        repeat (3) tick();

        // halted blocks fetch, data still served
        halted = 1'b1; if_req = 1'b1; if_addr = 32'd5;
        #1 check("halt_stall0", {31'b0, stall_if}, 0);
        gcnt = 0; scnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            gcnt += int'(if_gnt);
            scnt += int'(stall_if);
        end
        check("halt_no_gnt", gcnt, 0);
        check("halt_no_stall", scnt, 0);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'd200;
        tick();
        check("halt_dm_gnt", {30'b0, dm_gnt, if_gnt}, 2);
        dm_req = 1'b0;
        tick();
        check("halt_dm_rvalid", {31'b0, dm_rvalid}, 1);
        check("halt_dm_rdata", dm_rdata, 7);
        if_req = 1'b0; halted = 1'b0;
        repeat (2) tick();

        // reset during an in-flight fetch
        if_req = 1'b1; if_addr = 32'd5;
        tick();
        check("rf_gnt", {30'b0, if_gnt, mem_en}, 3);
        if_req = 1'b0;
        tick();
        rst_n = 1'b0;
        #1 check("rf_no_rvalid", {31'b0, if_rvalid}, 0);
        check("rf_no_rdata", if_rdata, 0);
        tick();
        check("rf_rst_outs", {28'b0, busy, mem_en, if_rvalid, if_gnt}, 0);
        check("rf_rst_addr", mem_addr, 0);
        rst_n = 1'b1; if_req = 1'b1;
        tick();
        check("rf_regnt", {31'b0, if_gnt}, 1);
        check("rf_readdr", mem_addr, 5);
        if_req = 1'b0;
        tick();
        check("rf_rvalid", {31'b0, if_rvalid}, 1);
        check("rf_rdata", if_rdata, 32'h14431000);
        tick();

        // MEM_LAT=3 back-to-back loads
        b_dm_req = 1'b1; b_dm_we = 1'b0; b_dm_addr = 32'd200;
        gm = '0; vm = '0; blo = 0; bad = 0;
        for (int c = 1; c < 14; c++) begin
            tick();
            gm[c] = b_dm_gnt;
            vm[c] = b_dm_rvalid;
            if (!b_busy)
                blo++;
            if (b_dm_rvalid && b_dm_rdata != 32'd7)
                bad++;
        end
        check("lat3_gnt_pattern", {18'b0, gm}, 32'h2222);
        check("lat3_rvalid_pattern", {18'b0, vm}, 32'h1110);
        check("lat3_busy_gaps", blo, 0);
        check("lat3_rdata", bad, 0);
        b_dm_req = 1'b0;
        repeat (6) tick();
        check("lat3_idle", {31'b0, b_busy}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
